// File: rtl/dff_pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dff_pipe_pkg : shared constants and sizing helper for the chain  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package dff_pipe_pkg;

    localparam int c_default_width = 8;
    localparam int c_default_depth = 4;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_pipe_chain_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dff_pipe_chain_if : valid/ready handshake bundle for the chain   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface dff_pipe_chain_if
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
);

    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [WIDTH-1:0]              out_data;
    logic [occ_width(DEPTH)-1:0]   occupancy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dff_pipe_stage : one valid/data register pair with load/drain    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dff_pipe_stage #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic             flush,
    input  wire logic             up_valid,
    input  wire logic [WIDTH-1:0] up_data,
    input  wire logic             dn_ready,
    output      logic             stage_ready,
    output      logic             valid,
    output      logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             w_load;

    // An empty stage accepts even if everything downstream is stalled.
    assign stage_ready = ~valid_q | dn_ready;
    assign w_load      = up_valid & stage_ready & ~flush;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (w_load) begin
            valid_d = 1'b1;
            data_d  = up_data;
        end else if (dn_ready & valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= RESET_DATA;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/dff_pipe_chain.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dff_pipe_chain : DEPTH-stage bubble-collapsing register pipeline |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dff_pipe_chain
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH      = c_default_width,
    parameter int               DEPTH      = c_default_depth,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    input  wire logic         flush,
    dff_pipe_chain_if.slave   bus
);

    localparam int c_occ_w = occ_width(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH:0]   w_rdy;
    logic [c_occ_w-1:0] w_occ;

    generate
        if (DEPTH < 1 || WIDTH < 1) begin : g_bad_params
            $error("dff_pipe_chain: DEPTH and WIDTH must both be at least 1");
        end
    endgenerate

    assign w_rdy[DEPTH] = bus.out_ready;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             w_up_valid;
            logic [WIDTH-1:0] w_up_data;

            if (i == 0) begin : g_head
                assign w_up_valid = bus.in_valid;
                assign w_up_data  = bus.in_data;
            end else begin : g_body
                assign w_up_valid = w_valid[i-1];
                assign w_up_data  = w_data[i-1];
            end

            dff_pipe_stage #(
                .WIDTH      (WIDTH),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk         (clk),
                .resetn      (resetn),
                .flush       (flush),
                .up_valid    (w_up_valid),
                .up_data     (w_up_data),
                .dn_ready    (w_rdy[i+1]),
                .stage_ready (w_rdy[i]),
                .valid       (w_valid[i]),
                .data        (w_data[i])
            );
        end
    endgenerate

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + c_occ_w'(w_valid[i]);
        end
    end

    // Flush masks both handshakes so nothing transfers in the flush cycle.
    assign bus.in_ready  = w_rdy[0] & ~flush;
    assign bus.out_valid = w_valid[DEPTH-1] & ~flush;
    assign bus.out_data  = w_data[DEPTH-1];
    assign bus.occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipe_chain.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dff_pipe_chain : directed scoreboard bench, DEPTH=4 and 1     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dff_pipe_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn_a, flush_a, resetn_b, flush_b;

    dff_pipe_chain_if #(.WIDTH(8), .DEPTH(4)) ifa ();
    dff_pipe_chain_if #(.WIDTH(8), .DEPTH(1)) ifb ();

    dff_pipe_chain #(.WIDTH(8), .DEPTH(4), .RESET_DATA(8'hA5)) u_dut_a (
        .clk    (clk),
        .resetn (resetn_a),
        .flush  (flush_a),
        .bus    (ifa)
    );

    dff_pipe_chain #(.WIDTH(8), .DEPTH(1), .RESET_DATA(8'h00)) u_dut_b (
        .clk    (clk),
        .resetn (resetn_b),
        .flush  (flush_b),
        .bus    (ifb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp_a, exp_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: accepted inputs are queued, each output transfer pops one.
    always @(negedge clk) begin
        if (!resetn_a || flush_a) begin
            qa.delete();
        end else begin
            if (ifa.out_valid && ifa.out_ready) begin
                n_tests++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a: got unexpected out_data %0h, expected no output", ifa.out_data);
                end else begin
                    exp_a = qa.pop_front();
                    if (ifa.out_data !== exp_a) begin
                        n_fail++;
                        $display("FAIL sb_a: got %0h, expected %0h", ifa.out_data, exp_a);
                    end
                end
            end
            if (ifa.in_valid && ifa.in_ready) qa.push_back(ifa.in_data);
        end
    end

    always @(negedge clk) begin
        if (!resetn_b || flush_b) begin
            qb.delete();
        end else begin
            if (ifb.out_valid && ifb.out_ready) begin
                n_tests++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b: got unexpected out_data %0h, expected no output", ifb.out_data);
                end else begin
                    exp_b = qb.pop_front();
                    if (ifb.out_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL sb_b: got %0h, expected %0h", ifb.out_data, exp_b);
                    end
                end
            end
            if (ifb.in_valid && ifb.in_ready) qb.push_back(ifb.in_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn_a = 1'b0; flush_a = 1'b0; resetn_b = 1'b0; flush_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.out_ready = 1'b0;

        // Reset
        step(); step();
        resetn_a = 1'b1; resetn_b = 1'b1;
        #1;
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_out_data",  ifa.out_data, 8'hA5);
        check("rst_occ",       ifa.occupancy, 0);
        check("rst_in_ready",  ifa.in_ready, 1);

        // Streaming
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifa.in_data = 8'(i + 1);
            step();
            #1;
            check("str_out_valid", ifa.out_valid, (i >= 3) ? 1 : 0);
            check("str_out_data",  ifa.out_data, (i >= 3) ? (i - 2) : 8'hA5);
            check("str_occ",       ifa.occupancy, (i >= 3) ? 4 : (i + 1));
            check("str_in_ready",  ifa.in_ready, 1);
        end
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("str_drained_occ", ifa.occupancy, 0);

        // Backpressure
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = 8'(8'h10 + i);
            #1;
            check("bp_in_ready_fill", ifa.in_ready, 1);
            step();
        end
        ifa.in_data = 8'h14;
        #1;
        check("bp_in_ready_full", ifa.in_ready, 0);
        check("bp_out_valid",     ifa.out_valid, 1);
        check("bp_out_data",      ifa.out_data, 8'h10);
        check("bp_occ",           ifa.occupancy, 4);
        step();
        #1;
        check("bp_hold_data", ifa.out_data, 8'h10);
        check("bp_hold_occ",  ifa.occupancy, 4);
        ifa.out_ready = 1'b1;
        #1;
        check("bp_in_ready_pass", ifa.in_ready, 1);
        step();
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b0;
        #1;
        check("bp_next_data", ifa.out_data, 8'h11);
        check("bp_next_occ",  ifa.occupancy, 4);
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("bp_drained_occ", ifa.occupancy, 0);

        // Bubble collapse
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 8'h20;
        step();
        ifa.in_valid = 1'b0;
        step(); step();
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'h21;
        step();
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #1;
        check("bub_occ",       ifa.occupancy, 2);
        check("bub_in_ready",  ifa.in_ready, 1);
        check("bub_out_valid", ifa.out_valid, 1);
        check("bub_out_data",  ifa.out_data, 8'h20);
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("bub_drained_occ", ifa.occupancy, 0);

        // Flush mid-stream
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = 8'(8'h30 + i);
            step();
        end
        ifa.in_valid = 1'b0;
        step();
        #1;
        check("fl_pre_occ",       ifa.occupancy, 3);
        check("fl_pre_out_valid", ifa.out_valid, 1);
        flush_a       = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 8'h33;
        ifa.out_ready = 1'b1;
        #1;
        check("fl_in_ready",  ifa.in_ready, 0);
        check("fl_out_valid", ifa.out_valid, 0);
        step();
        flush_a      = 1'b0;
        ifa.in_valid = 1'b0;
        #1;
        check("fl_post_occ",      ifa.occupancy, 0);
        check("fl_post_in_ready", ifa.in_ready, 1);
        check("fl_post_data",     ifa.out_data, 8'h30);
        for (int i = 0; i < 5; i++) begin
            step();
            check("fl_no_output", ifa.out_valid, 0);
        end

        // Reset wins over flush
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_data   = 8'h40;
        step();
        ifa.in_data = 8'h41;
        step();
        ifa.in_valid = 1'b0;
        resetn_a = 1'b0;
        flush_a  = 1'b1;
        step();
        resetn_a = 1'b1;
        flush_a  = 1'b0;
        #1;
        check("rf_out_valid", ifa.out_valid, 0);
        check("rf_out_data",  ifa.out_data, 8'hA5);
        check("rf_occ",       ifa.occupancy, 0);
        check("rf_in_ready",  ifa.in_ready, 1);

        // DEPTH=1
        ifb.in_valid = 1'b1;
        ifb.in_data  = 8'h7F;
        #1;
        check("d1_in_ready_empty", ifb.in_ready, 1);
        step();
        ifb.in_data = 8'h80;
        #1;
        check("d1_out_valid",     ifb.out_valid, 1);
        check("d1_out_data",      ifb.out_data, 8'h7F);
        check("d1_occ",           ifb.occupancy, 1);
        check("d1_in_ready_full", ifb.in_ready, 0);
        step();
        #1;
        check("d1_hold_data", ifb.out_data, 8'h7F);
        ifb.out_ready = 1'b1;
        #1;
        check("d1_in_ready_pass", ifb.in_ready, 1);
        step();
        ifb.in_valid = 1'b0;
        #1;
        check("d1_next_data", ifb.out_data, 8'h80);
        step();
        check("d1_drained_occ", ifb.occupancy, 0);

        step();
        check("sb_a_empty", qa.size(), 0);
        check("sb_b_empty", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
